// File: rtl/i2c_target_rx.sv
//------------------------------------------------------------------------------
// i2c_target_rx : I2C write-only target; address match, ACK, clock stretch
// toward a valid/ready byte sink. Optional macro: I2C_GENCALL_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
`ifdef I2C_GENCALL_EN
  output logic       rx_gencall,
`endif
  output logic       bus_stop
);

  localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_STRETCH, S_DATA_ACK, S_IGNORE
  } state_t;

  logic [c_stages-1:0] r_scl_sync, r_sda_sync;
  logic                r_scl_prev, r_sda_prev;
  logic                w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       r_first_flag, w_first_nx;
  logic       w_scl_oe_nx, w_sda_oe_nx, w_load, w_addr_hit;

  // Idle bus level is high, so the synchronisers reset to 1 to avoid false edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[c_stages-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[c_stages-2:0], sda_in};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[c_stages-1];
  assign w_sda      = r_sda_sync[c_stages-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = r_sda_prev & ~w_sda & w_scl & r_scl_prev;
  assign w_stop     = ~r_sda_prev & w_sda & w_scl & r_scl_prev;

`ifdef I2C_GENCALL_EN
  assign w_addr_hit = ~r_shift[0] & ((r_shift[7:1] == ADDR) | (r_shift[7:1] == 7'h00));
`else
  assign w_addr_hit = ~r_shift[0] & (r_shift[7:1] == ADDR);
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_shift_nx  = r_shift;
    w_first_nx  = r_first_flag;
    w_scl_oe_nx = scl_oe;
    w_sda_oe_nx = sda_oe;
    w_load      = 1'b0;
    if (w_start) begin
      w_state_nx  = S_ADDR;
      w_cnt_nx    = 4'd0;
      w_scl_oe_nx = 1'b0;
      w_sda_oe_nx = 1'b0;
    end else if (w_stop) begin
      w_state_nx  = S_IDLE;
      w_scl_oe_nx = 1'b0;
      w_sda_oe_nx = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_DATA: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_shift_nx = {r_shift[6:0], w_sda};
            w_cnt_nx   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            if (r_state == S_ADDR) begin
              w_state_nx  = w_addr_hit ? S_ADDR_ACK : S_IGNORE;
              w_sda_oe_nx = w_addr_hit;
            end else if (!rx_valid || rx_ready) begin
              w_load      = 1'b1;
              w_first_nx  = 1'b0;
              w_sda_oe_nx = 1'b1;
              w_state_nx  = S_DATA_ACK;
            end else begin
              w_scl_oe_nx = 1'b1;
              w_state_nx  = S_STRETCH;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_state_nx  = S_DATA;
            w_cnt_nx    = 4'd0;
            w_sda_oe_nx = 1'b0;
            w_first_nx  = 1'b1;
          end
        end
        S_STRETCH: begin
          // ACK is driven in the same clock that SCL is let go
          if (rx_ready) begin
            w_load      = 1'b1;
            w_first_nx  = 1'b0;
            w_scl_oe_nx = 1'b0;
            w_sda_oe_nx = 1'b1;
            w_state_nx  = S_DATA_ACK;
          end
        end
        S_DATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nx  = S_DATA;
            w_cnt_nx    = 4'd0;
            w_sda_oe_nx = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_shift      <= 8'd0;
      r_first_flag <= 1'b0;
      scl_oe       <= 1'b0;
      sda_oe       <= 1'b0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_first     <= 1'b0;
      bus_stop     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_shift      <= w_shift_nx;
      r_first_flag <= w_first_nx;
      scl_oe       <= w_scl_oe_nx;
      sda_oe       <= w_sda_oe_nx;
      bus_stop     <= w_stop && (r_state != S_IDLE) && (r_state != S_IGNORE);
      if (w_load) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
        rx_first <= r_first_flag;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef I2C_GENCALL_EN
  logic r_gc_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gc_match <= 1'b0;
      rx_gencall <= 1'b0;
    end else if (w_stop) begin
      r_gc_match <= 1'b0;
      rx_gencall <= 1'b0;
    end else begin
      if (r_state == S_ADDR && w_state_nx == S_ADDR_ACK)
        r_gc_match <= (r_shift[7:1] == 7'h00);
      if (w_load)
        rx_gencall <= r_gc_match;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_rx.sv
//------------------------------------------------------------------------------
// tb_i2c_target_rx : randomized I2C controller + byte sink around i2c_target_rx,
// predicting received bytes from the addressing rules.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target_rx;

  localparam int Q = 6;
  localparam int TIMEOUT = 5000;
`ifdef I2C_GENCALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_drv = 1'b1, sda_drv = 1'b1;
  logic       scl_in, sda_in;
  logic       scl_oe, sda_oe, rx_valid, rx_first, bus_stop;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
`ifdef I2C_GENCALL_EN
  logic       rx_gencall;
`endif

  assign scl_in = scl_drv & ~scl_oe;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_target_rx #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_first (rx_first),
`ifdef I2C_GENCALL_EN
    .rx_gencall (rx_gencall),
`endif
    .bus_stop (bus_stop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       g;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] dbuf[4];
  int         n_pass = 0, n_total = 0;
  int         sink_mode = 0, stretch_cnt = 0;
  bit         mon_en = 1'b0;
  int         stop_pulses = 0, sda_cycles = 0, stab_err = 0, excl_err = 0;
  logic       prev_hold = 1'b0, prev_scl_oe = 1'b0;
  logic [7:0] prev_data = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic consume();
    exp_t e;
    check_eq("rx_byte_expected", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("rx_data", rx_data, e.d);
      check_eq("rx_first", rx_first, e.f);
`ifdef I2C_GENCALL_EN
      check_eq("rx_gencall", rx_gencall, e.g);
`endif
    end
  endtask

  // Sink and bus monitor, sampled on the falling clock edge
  always @(negedge clk) begin
    if (rst && mon_en) begin
      stretch_cnt = scl_oe ? stretch_cnt + 1 : 0;
      case (sink_mode)
        0:       rx_ready = 1'b1;
        1:       rx_ready = 1'($urandom_range(0, 1));
        2:       rx_ready = (stretch_cnt >= 50);
        default: rx_ready = 1'b0;
      endcase
      if (bus_stop) stop_pulses++;
      if (sda_oe) sda_cycles++;
      if (sda_oe && scl_oe) excl_err++;
      if (prev_hold && rx_data !== prev_data) stab_err++;
      if (prev_scl_oe && !scl_oe) check_eq("ack_on_release", sda_oe, 1'b1);
      if (rx_valid && rx_ready) consume();
      prev_hold   = rx_valid && !rx_ready;
      prev_data   = rx_data;
      prev_scl_oe = scl_oe;
    end else begin
      rx_ready    = 1'b0;
      prev_hold   = 1'b0;
      prev_scl_oe = 1'b0;
      stretch_cnt = 0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_drv = 1'b1;
    while (scl_in !== 1'b1 && t < TIMEOUT) begin
      wait_clk(1);
      t++;
    end
    if (t >= TIMEOUT) begin
      check_eq("scl_release_timeout", t, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "SCL held low too long");
    end
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_drv = b;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    s = sda_in;
    wait_clk(Q);
    scl_drv = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic start_cond();
    sda_drv = 1'b1;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    sda_drv = 1'b0;
    wait_clk(Q);
    scl_drv = 1'b0;
    wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_drv = 1'b0;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    sda_drv = 1'b1;
    wait_clk(Q);
  endtask

  // One addressed transfer; cut>0 ends with cut bits of a partial byte and no STOP
  task automatic xfer(input logic [7:0] ab, input int nb, input int cut);
    logic ack, s, hit;
    exp_t e;
    hit = ((ab[7:1] == 7'h42) && !ab[0]) || (GC && ab == 8'h00);
    stop_pulses = 0;
    sda_cycles  = 0;
    start_cond();
    send_byte(ab, ack);
    check_eq("addr_ack", ack, hit);
    for (int i = 0; i < nb; i++) begin
      if (hit) begin
        e.d = dbuf[i];
        e.f = (i == 0);
        e.g = GC && (ab == 8'h00);
        exp_q.push_back(e);
      end
      send_byte(dbuf[i], ack);
      check_eq("data_ack", ack, hit);
    end
    if (cut > 0) begin
      for (int k = 0; k < cut; k++) send_bit(1'($urandom_range(0, 1)), s);
    end else begin
      stop_cond();
      wait_clk(4);
      check_eq("bus_stop_pulses", stop_pulses, hit);
`ifdef I2C_GENCALL_EN
      check_eq("gencall_clr_on_stop", rx_gencall, 1'b0);
`endif
    end
    if (!hit) check_eq("no_sda_oe_when_unaddressed", sda_cycles, 0);
  endtask

  initial begin
    logic [7:0] ab;
    logic [6:0] a7;
    logic       ack;
    int         cut, nb, t;

    wait_clk(5);
    check_eq("rst_scl_oe", scl_oe, 1'b0);
    check_eq("rst_sda_oe", sda_oe, 1'b0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_rx_first", rx_first, 1'b0);
    check_eq("rst_bus_stop", bus_stop, 1'b0);
`ifdef I2C_GENCALL_EN
    check_eq("rst_rx_gencall", rx_gencall, 1'b0);
`endif
    rst = 1'b1;
    wait_clk(5);
    mon_en = 1'b1;

    sink_mode = 0;
    dbuf[0] = 8'hA5;
    xfer(8'h84, 1, 0);
    xfer(8'h85, 1, 0);
    xfer(8'h86, 1, 0);

    sink_mode = 2;
    dbuf[0] = 8'h11;
    dbuf[1] = 8'h22;
    xfer(8'h84, 2, 0);

    sink_mode = 0;
    wait_clk(5);
    dbuf[0] = 8'h77;
    xfer(8'h84, 1, 5);
    dbuf[0] = 8'h3C;
    xfer(8'h84, 1, 0);

    dbuf[0] = 8'h06;
    xfer(8'h00, 1, 0);

    for (int n = 0; n < 20; n++) begin
      sink_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0, 1:    ab = 8'h84;
        2:       ab = 8'h85;
        default: begin
          a7 = 7'($urandom_range(1, 127));
          if (a7 == 7'h42) a7 = 7'h43;
          ab = {a7, 1'($urandom_range(0, 1))};
        end
      endcase
      nb  = $urandom_range(1, 3);
      cut = ($urandom_range(0, 3) == 0 && n != 19) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
      xfer(ab, nb, cut);
    end

    sink_mode = 0;
    wait_clk(20);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("valid_after_drain", rx_valid, 1'b0);

    // Reset while stretching
    sink_mode = 3;
    dbuf[0] = 8'h5A;
    dbuf[1] = 8'hC3;
    start_cond();
    send_byte(8'h84, ack);
    check_eq("rst_case_addr_ack", ack, 1'b1);
    exp_q.push_back('{d: 8'h5A, f: 1'b1, g: 1'b0});
    send_byte(dbuf[0], ack);
    check_eq("rst_case_data_ack", ack, 1'b1);
    for (int i = 7; i >= 0; i--) send_bit(dbuf[1][i], ack);
    t = 0;
    while (!scl_oe && t < 50) begin
      wait_clk(1);
      t++;
    end
    check_eq("stretch_entered", scl_oe, 1'b1);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_scl_oe", scl_oe, 1'b0);
    check_eq("async_rst_sda_oe", sda_oe, 1'b0);
    check_eq("async_rst_rx_valid", rx_valid, 1'b0);
    check_eq("async_rst_rx_data", rx_data, 8'h00);
    exp_q.delete();
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(5);
    mon_en = 1'b1;
    sink_mode = 0;
    stop_pulses = 0;
    sda_cycles = 0;
    scl_drv = 1'b0;
    wait_clk(Q);
    send_byte(8'h84, ack);
    check_eq("idle_no_ack_without_start", ack, 1'b0);
    stop_cond();
    wait_clk(4);
    check_eq("idle_no_sda_oe", sda_cycles, 0);
    check_eq("idle_no_bus_stop", stop_pulses, 0);
    check_eq("idle_no_rx_valid", rx_valid, 1'b0);

    dbuf[0] = 8'h9E;
    xfer(8'h84, 1, 0);
    wait_clk(10);
    check_eq("final_queue_drained", exp_q.size(), 0);
    check_eq("oe_never_both", excl_err, 0);
    check_eq("rx_data_stable_while_held", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
